// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Used by the fetch-address generator and its interface.
package cpu_pkg;

    typedef enum logic {
        PCG_RESET = 1'b0,
        PCG_RUN   = 1'b1
    } pcg_state_e;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int INSN_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-address generator bus: redirect inputs and fetch request outputs.
// The pipeline side uses master, pc_gen uses slave.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int FETCH_N = 1,
    parameter int STALL_W = 6
);

    logic [STALL_W-1:0] stall;
    logic               flush_i;
    logic [ADDR_W-1:0]  flush_target_i;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_i;
    logic               fetch_ready_i;
    logic [ADDR_W-1:0]  pc_o;
    logic [ADDR_W-1:0]  fetch_pc_o;
    logic [FETCH_N-1:0] fetch_mask_o;
    logic               fetch_valid_o;
    logic               ce_o;

    modport master (
        output stall, flush_i, flush_target_i,
        output branch_flag_i, branch_target_i, fetch_ready_i,
        input  pc_o, fetch_pc_o, fetch_mask_o,
        input  fetch_valid_o, ce_o
    );

    modport slave (
        input  stall, flush_i, flush_target_i,
        input  branch_flag_i, branch_target_i, fetch_ready_i,
        output pc_o, fetch_pc_o, fetch_mask_o,
        output fetch_valid_o, ce_o
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer for a branch target that arrived while fetch was blocked.
// Clear beats set; a new set overwrites any older target.
module pc_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_clear,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_target
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_target;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
        end else if (i_set && !i_clear) begin
            r_target <= i_target;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/pc_gen.sv
// Program counter and fetch-block request generator for the front end.
// Flush > live branch > buffered branch > sequential block step.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                FETCH_N  = 1,
    parameter int                STALL_W  = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  pcg
);

    localparam int BLK_BYTES = FETCH_N * INSN_BYTES;

    pcg_state_e        r_state;
    pcg_state_e        w_state_nxt;
    logic              w_ce;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_fetch_pc;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_fl_tgt;
    logic [ADDR_W-1:0] w_off;
    logic [FETCH_N-1:0] w_mask;
    logic              w_adv;
    logic              w_buf_set;
    logic              w_buf_clr;
    logic              w_buf_valid;
    logic [ADDR_W-1:0] w_buf_tgt;

    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ce        = CHIP_DISABLE;
        unique case (r_state)
            PCG_RESET: begin
                w_ce = CHIP_DISABLE;
                if (!rst) w_state_nxt = PCG_RUN;
            end
            PCG_RUN: begin
                w_ce = CHIP_ENABLE;
            end
        endcase
        if (rst) w_state_nxt = PCG_RESET;
    end

    assign w_adv = w_ce & ~pcg.stall[0] & pcg.fetch_ready_i;

    assign w_fetch_pc = r_pc & ~ADDR_W'(BLK_BYTES - 1);
    assign w_seq_pc   = w_fetch_pc + ADDR_W'(BLK_BYTES);
    assign w_br_tgt   = {pcg.branch_target_i[ADDR_W-1:2], 2'b00};
    assign w_fl_tgt   = {pcg.flush_target_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_pc_nxt  = r_pc;
        w_buf_set = 1'b0;
        w_buf_clr = 1'b0;
        if (w_ce == CHIP_ENABLE) begin
            if (pcg.flush_i) begin
                w_pc_nxt  = w_fl_tgt;
                w_buf_clr = 1'b1;
            end else if (w_adv) begin
                w_buf_clr = 1'b1;
                if (pcg.branch_flag_i) w_pc_nxt = w_br_tgt;
                else if (w_buf_valid)  w_pc_nxt = w_buf_tgt;
                else                   w_pc_nxt = w_seq_pc;
            end else if (pcg.branch_flag_i) begin
                w_buf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_nxt;
    end

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .i_set    (w_buf_set),
        .i_target (w_br_tgt),
        .i_clear  (w_buf_clr),
        .o_valid  (w_buf_valid),
        .o_target (w_buf_tgt)
    );

    // Word offset of the PC inside its fetch block.
    assign w_off = (r_pc >> 2) & ADDR_W'(FETCH_N - 1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FETCH_N; i++) begin
            w_mask[i] = (ADDR_W'(i) >= w_off);
        end
    end

    assign pcg.pc_o          = r_pc;
    assign pcg.fetch_pc_o    = w_fetch_pc;
    assign pcg.fetch_mask_o  = w_mask;
    assign pcg.fetch_valid_o = w_ce;
    assign pcg.ce_o          = w_ce;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with FETCH_N = 1, 2 and 4 instances.
// All instances share clk/rst; each scenario drives one instance's bus.
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .FETCH_N(1), .STALL_W(6)) b1 ();
    pc_gen_if #(.ADDR_W(32), .FETCH_N(2), .STALL_W(6)) b2 ();
    pc_gen_if #(.ADDR_W(32), .FETCH_N(4), .STALL_W(6)) b4 ();

    pc_gen #(
        .ADDR_W(32), .RESET_PC(32'hBFC0_0000), .FETCH_N(1), .STALL_W(6)
    ) u1 (.clk(clk), .rst(rst), .pcg(b1.slave));

    pc_gen #(
        .ADDR_W(32), .RESET_PC(32'hBFC0_0000), .FETCH_N(2), .STALL_W(6)
    ) u2 (.clk(clk), .rst(rst), .pcg(b2.slave));

    pc_gen #(
        .ADDR_W(32), .RESET_PC(32'hBFC0_0000), .FETCH_N(4), .STALL_W(6)
    ) u4 (.clk(clk), .rst(rst), .pcg(b4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        b1.stall = '0; b1.flush_i = 0; b1.flush_target_i = '0;
        b1.branch_flag_i = 0; b1.branch_target_i = '0; b1.fetch_ready_i = 1;
        b2.stall = '0; b2.flush_i = 0; b2.flush_target_i = '0;
        b2.branch_flag_i = 0; b2.branch_target_i = '0; b2.fetch_ready_i = 1;
        b4.stall = '0; b4.flush_i = 0; b4.flush_target_i = '0;
        b4.branch_flag_i = 0; b4.branch_target_i = '0; b4.fetch_ready_i = 1;

        // reset held three cycles
        tick(); chk("rst_ce0", 32'(b1.ce_o), 32'd0);
        tick(); chk("rst_ce1", 32'(b1.ce_o), 32'd0);
        tick(); chk("rst_ce2", 32'(b1.ce_o), 32'd0);
        chk("rst_pc", b1.pc_o, 32'hBFC0_0000);
        chk("rst_valid", 32'(b1.fetch_valid_o), 32'd0);

        // release; redirects on the RESET->RUN edge are ignored
        rst = 1'b0;
        b1.flush_i = 1; b1.flush_target_i = 32'h0000_1234;
        b1.branch_flag_i = 1; b1.branch_target_i = 32'h0000_5678;
        tick();
        b1.flush_i = 0; b1.branch_flag_i = 0;
        chk("rel_ce", 32'(b1.ce_o), 32'd1);
        chk("rel_valid", 32'(b1.fetch_valid_o), 32'd1);
        chk("rel_pc", b1.pc_o, 32'hBFC0_0000);
        tick(); chk("seq_pc1", b1.pc_o, 32'hBFC0_0004);
        tick(); chk("seq_pc2", b1.pc_o, 32'hBFC0_0008);
        chk("n1_mask", 32'(b1.fetch_mask_o), 32'd1);

        // FETCH_N=4 branch on an advance edge
        b4.branch_flag_i = 1; b4.branch_target_i = 32'h0000_1008;
        tick();
        b4.branch_flag_i = 0;
        chk("br_pc", b4.pc_o, 32'h0000_1008);
        chk("br_fpc", b4.fetch_pc_o, 32'h0000_1000);
        chk("br_mask", 32'(b4.fetch_mask_o), 32'hC);
        tick();
        chk("br_seq_pc", b4.pc_o, 32'h0000_1010);
        chk("br_seq_mask", 32'(b4.fetch_mask_o), 32'hF);

        // buffered branch across a 4-cycle stall
        b4.stall = 6'h01;
        b4.branch_flag_i = 1; b4.branch_target_i = 32'h0000_2000;
        tick();
        b4.branch_flag_i = 0;
        chk("stl_hold0", b4.pc_o, 32'h0000_1010);
        tick(); tick(); tick();
        chk("stl_hold3", b4.pc_o, 32'h0000_1010);
        chk("stl_valid", 32'(b4.fetch_valid_o), 32'd1);
        b4.stall = 6'h00;
        tick();
        chk("stl_rel", b4.pc_o, 32'h0000_2000);

        // upper stall bits do not block
        b4.stall = 6'h3E;
        tick();
        chk("stl_hi", b4.pc_o, 32'h0000_2010);
        b4.stall = 6'h00;

        // newest blocked branch wins
        b4.stall = 6'h01;
        b4.branch_flag_i = 1; b4.branch_target_i = 32'h0000_3000;
        tick();
        b4.branch_target_i = 32'h0000_4000;
        tick();
        b4.branch_flag_i = 0;
        chk("nw_hold", b4.pc_o, 32'h0000_2010);
        b4.stall = 6'h00;
        tick();
        chk("nw_pc", b4.pc_o, 32'h0000_4000);
        tick();
        chk("nw_seq", b4.pc_o, 32'h0000_4010);

        // flush during stall clears the pending target
        b1.stall = 6'h01;
        b1.branch_flag_i = 1; b1.branch_target_i = 32'h0000_5000;
        tick();
        b1.branch_flag_i = 0;
        b1.flush_i = 1; b1.flush_target_i = 32'hBFC0_0380;
        tick();
        b1.flush_i = 0;
        chk("fl_pc", b1.pc_o, 32'hBFC0_0380);
        tick();
        chk("fl_hold", b1.pc_o, 32'hBFC0_0380);
        b1.stall = 6'h00;
        tick();
        chk("fl_seq", b1.pc_o, 32'hBFC0_0384);

        // fetch_ready_i low for two cycles
        b4.flush_i = 1; b4.flush_target_i = 32'h0000_6006;
        tick();
        b4.flush_i = 0;
        chk("rdy_pc", b4.pc_o, 32'h0000_6004);
        chk("rdy_mask", 32'(b4.fetch_mask_o), 32'hE);
        b4.fetch_ready_i = 0;
        tick();
        chk("rdy_hold_pc1", b4.pc_o, 32'h0000_6004);
        chk("rdy_hold_msk1", 32'(b4.fetch_mask_o), 32'hE);
        chk("rdy_hold_vld1", 32'(b4.fetch_valid_o), 32'd1);
        tick();
        chk("rdy_hold_pc2", b4.pc_o, 32'h0000_6004);
        chk("rdy_hold_vld2", 32'(b4.fetch_valid_o), 32'd1);
        b4.fetch_ready_i = 1;
        tick();
        chk("rdy_adv", b4.pc_o, 32'h0000_6010);
        chk("rdy_adv_msk", 32'(b4.fetch_mask_o), 32'hF);

        // FETCH_N=2 mask and wrap
        b2.flush_i = 1; b2.flush_target_i = 32'h0000_7006;
        tick();
        chk("n2_pc", b2.pc_o, 32'h0000_7004);
        chk("n2_fpc", b2.fetch_pc_o, 32'h0000_7000);
        chk("n2_mask", 32'(b2.fetch_mask_o), 32'h2);
        b2.flush_target_i = 32'hFFFF_FFFB;
        tick();
        b2.flush_i = 0;
        chk("wr_pc", b2.pc_o, 32'hFFFF_FFF8);
        chk("wr_mask", 32'(b2.fetch_mask_o), 32'h3);
        tick();
        chk("wr_wrap", b2.pc_o, 32'h0000_0000);
        chk("wr_fpc", b2.fetch_pc_o, 32'h0000_0000);

        // reset mid-stall drops the pending target
        b4.stall = 6'h01;
        b4.branch_flag_i = 1; b4.branch_target_i = 32'h0000_8000;
        tick();
        b4.branch_flag_i = 0;
        rst = 1'b1;
        tick();
        chk("mr_ce", 32'(b4.ce_o), 32'd0);
        chk("mr_pc", b4.pc_o, 32'hBFC0_0000);
        rst = 1'b0;
        tick();
        chk("mr_run", 32'(b4.ce_o), 32'd1);
        chk("mr_hold", b4.pc_o, 32'hBFC0_0000);
        b4.stall = 6'h00;
        tick();
        chk("mr_seq", b4.pc_o, 32'hBFC0_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
